pattern_scheduler: RTL

//  Parametrised successor to the per-solver pattern walker. Scans a rectangular region
//  of the complex plane by pixel counts rather than coordinate compares. Issues (c_re,
//  c_im, col, row) jobs to one solver lane over a valid/ready handshake. Rows are

---
 rtl/pattern_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
// Pixel-count region walker: issues (c_re, c_im, col, row) jobs for one solver lane,
// interleaving rows across lanes and capping jobs in flight with a credit count.
module pattern_scheduler #(
  parameter int COORD_W         = 27,
  parameter int DIM_W           = 11,
  parameter int SOLVER_ID       = 0,
  parameter int NUM_SOLVERS     = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  input  logic [DIM_W-1:0]   cols,
  input  logic [DIM_W-1:0]   rows,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [COORD_W-1:0] job_re,
  output logic [COORD_W-1:0] job_im,
  output logic [DIM_W-1:0]   job_col,
  output logic [DIM_W-1:0]   job_row,
  input  logic               res_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [COORD_W-1:0] ID_C  = COORD_W'(SOLVER_ID);
  localparam logic [COORD_W-1:0] NS_C  = COORD_W'(NUM_SOLVERS);
  localparam logic [DIM_W:0]     ID_W  = (DIM_W+1)'(SOLVER_ID);
  localparam logic [DIM_W:0]     NS_W  = (DIM_W+1)'(NUM_SOLVERS);
  localparam logic [DIM_W-1:0]   NS_R  = DIM_W'(NUM_SOLVERS);
  localparam logic [OW-1:0]      MAX_C = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] minx_q, minx_d, dx_q, dx_d, dystep_q, dystep_d;
  logic [COORD_W-1:0] re_q, re_d, im_q, im_d;
  logic [DIM_W-1:0]   cols_q, cols_d, rows_q, rows_d, col_q, col_d, row_q, row_d;
  logic [OW-1:0]      out_q, out_d;
  logic               aborted_q, aborted_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               accept, end_of_row, last_job, empty;

  always_comb begin
    state_d    = state_q;
    minx_d     = minx_q;
    dx_d       = dx_q;
    dystep_d   = dystep_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    col_d      = col_q;
    row_d      = row_q;
    re_d       = re_q;
    im_d       = im_q;
    out_d      = out_q;
    aborted_d  = aborted_q;
    err_d      = err_q;
    job_valid  = (state_q == S_RUN) && (out_q < MAX_C);
    accept     = job_valid && job_ready;
    end_of_row = (col_q == cols_q - DIM_W'(1));
    // Widened compare so row+NUM_SOLVERS cannot wrap past rows.
    last_job   = end_of_row && (({1'b0, row_q} + NS_W) >= {1'b0, rows_q});
    empty      = (cols == '0) || ({1'b0, rows} <= ID_W);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          minx_d    = min_x;
          dx_d      = dx;
          dystep_d  = dy * NS_C;
          cols_d    = cols;
          rows_d    = rows;
          col_d     = '0;
          row_d     = DIM_W'(SOLVER_ID);
          re_d      = min_x;
          im_d      = min_y + dy * ID_C;
          aborted_d = 1'b0;
          // An empty region has nothing to issue; it drains straight to DONE.
          state_d   = empty ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (end_of_row) begin
            col_d = '0;
            re_d  = minx_q;
            row_d = row_q + NS_R;
            im_d  = im_q + dystep_q;
          end else begin
            col_d = col_q + DIM_W'(1);
            re_d  = re_q + dx_q;
          end
          if (last_job) state_d = S_DRAIN;
        end
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = aborted_q ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({accept, res_valid})
      2'b10: out_d = out_q + OW'(1);
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - OW'(1);
      end
      default: ;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      minx_q    <= '0;
      dx_q      <= '0;
      dystep_q  <= '0;
      cols_q    <= '0;
      rows_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
      out_q     <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      minx_q    <= minx_d;
      dx_q      <= dx_d;
      dystep_q  <= dystep_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      col_q     <= col_d;
      row_q     <= row_d;
      re_q      <= re_d;
      im_q      <= im_d;
      out_q     <= out_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign job_re  = re_q;
  assign job_im  = im_q;
  assign job_col = col_q;
  assign job_row = row_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
